fetch_memory_responder: RTL
===========================

Name: fetch_memory_responder

Overview:
- Responder end of the instruction-fetch memory bus. It accepts 64-bit-aligned read requests from the fetch stage and returns one 64-bit payload per request, holding two packed instructions, tagged with the requester id.
- Backed by an internal word array. The host loads that array through a side port before or between runs.
- Sits between the fetch stage's memory bus port and the program image.

Parameters:
- ADDR_W, 64, width of memory_address_t.
- ID_W, 4, width of the requester id (memory_bus_id).
- DEPTH_WORDS, 1024, number of 64-bit words; power of two.
- READ_LATENCY, 2, cycles from dequeue to resp_valid; legal range 1..15.
- REQ_FIFO_DEPTH, 4, request buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  read request present
- req_ready  out  1  request buffer has space
- req_addr  in  ADDR_W  byte address
- req_id  in  ID_W  requester id
- resp_valid  out  1  response available (the fetch side's "response_busy")
- resp_ready  in  1  fetch consumes the response this cycle
- resp_type  out  2  0=bus_read_response, 2=bus_error_response
- resp_payload  out  64  fetched_instruction_data_t
- resp_id  out  ID_W  echoed req_id
- ld_en  in  1  loader write strobe
- ld_index  in  log2(DEPTH_WORDS)  word index
- ld_data  in  64  word to write

Behaviour:
- Reset: req_ready=0 during reset, then 1. resp_valid=0, resp_type=0, resp_payload=0, resp_id=0. FIFO emptied; FSM goes to IDLE. The memory array is not cleared.
- Reset mid-operation: in-flight and buffered requests are discarded and no response is emitted for them.
- Request accept: a request is accepted on a cycle where req_valid && req_ready. It is pushed into the FIFO with {addr, id}.
- req_ready = !fifo_full. It is registered-combinational from FIFO occupancy. A push and a pop in the same cycle on a full FIFO is not allowed: req_ready stays 0 when full.
- Address: word index = req_addr[3 +: log2(DEPTH_WORDS)]. Bits [2:0] are ignored. If any bit above the index field is nonzero, the access is out of range.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head, load the latency counter with READ_LATENCY-1, and go to WAIT.
  - WAIT: decrement the counter. When it reaches 0, sample the memory (or the error case), register the response, assert resp_valid, and go to RESPOND.
  - RESPOND: hold all resp_* stable while resp_valid && !resp_ready. On resp_ready, deassert resp_valid. If the FIFO is not empty, pop immediately and go to WAIT (back-to-back); otherwise go to IDLE.
- Timing: resp_valid rises exactly READ_LATENCY+1 cycles after the accept cycle when the FIFO was empty and the FSM was IDLE.
- Out of range: resp_type=2, resp_payload=0, resp_id echoed. The response is still emitted so the requester never hangs.
- Ordering: responses are strictly in request order, one per request.
- Loader:
  - On ld_en, mem[ld_index] <= ld_data.
  - If a load and the WAIT-exit sample hit the same word in the same cycle, the response returns the old data (read-before-write).
  - Loader writes never stall requests.
- resp_valid never drops without resp_ready. The payload never changes while resp_valid && !resp_ready.

Optional Feature:
- Macro FETCH_RESPONDER_STATS_EN.
- When defined, adds these outputs:
  - stat_reads (32b): increments on each response handshake with type 0.
  - stat_errors (32b): increments on each handshake with type 2.
  - stat_backpressure (32b): increments each cycle with resp_valid && !resp_ready.
  - All three clear on reset and saturate at all-ones.
- When undefined, the ports and counters are absent and functional behaviour is identical.

Test Plan:
- Single read, READ_LATENCY=2:
  - Stimulus: load mem[5]=64'h0000_0011_0000_0022, reset deasserted, request addr=40 id=3 at cycle t, resp_ready=1.
  - Required: resp_valid at t+3, payload 64'h0000_0011_0000_0022, id=3, type=0, exactly one response.
- Misaligned address:
  - Stimulus: request addr=45 (mem[5] loaded as above).
  - Required: same word as addr=40.
- Out of range, DEPTH_WORDS=1024:
  - Stimulus: request addr=64'h2000 (index field overflow).
  - Required: type=2, payload=0, id echoed.
- Backpressure:
  - Stimulus: 5 back-to-back requests ids 0..4, resp_ready held 0 for 10 cycles, then 1.
  - Required: req_ready falls after 4 buffered plus 1 in flight. Responses come in id order 0..4 with payload stable while stalled. With FETCH_RESPONDER_STATS_EN, stat_backpressure ≥ 10.
- Load collision:
  - Stimulus: old mem[7]=A. ld_en writes mem[7]=B in the WAIT-exit cycle of a read to addr=56.
  - Required: response A. The next read of addr=56 returns B.
- Mid-flight reset:
  - Stimulus: assert reset for 1 cycle while in WAIT with 2 buffered requests.
  - Required: no responses emitted; resp_valid=0; the next new request is served normally.

Source files
------------

// File: rtl/fetch_memory_responder.sv
// fetch_memory_responder: instruction-fetch bus responder backed by a host-loaded 64-bit word array
// Ports: clk/reset (sync, active-high); req_valid/req_ready/req_addr/req_id read request in;
// resp_valid/resp_ready/resp_type/resp_payload/resp_id response out (type 0 read, 2 error);
// ld_en/ld_index/ld_data host loader write port.
// Optional macro FETCH_RESPONDER_STATS_EN adds saturating stat_reads/stat_errors/stat_backpressure.
module fetch_memory_responder #(
  parameter int ADDR_W = 64,
  parameter int ID_W = 4,
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LATENCY = 2,
  parameter int REQ_FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_W-1:0]              req_addr,
  input  logic [ID_W-1:0]                req_id,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [1:0]                     resp_type,
  output logic [63:0]                    resp_payload,
  output logic [ID_W-1:0]                resp_id,
`ifdef FETCH_RESPONDER_STATS_EN
  output logic [31:0]                    stat_reads,
  output logic [31:0]                    stat_errors,
  output logic [31:0]                    stat_backpressure,
`endif
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_index,
  input  logic [63:0]                    ld_data
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int FW = $clog2(REQ_FIFO_DEPTH);
  localparam int EW = 1 + IW + ID_W;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;
  state_t state;
  logic [63:0] mem [DEPTH_WORDS];
  logic [EW-1:0] fifo [REQ_FIFO_DEPTH];
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [FW:0] count;
  logic [3:0] cnt;
  logic cur_oor;
  logic [IW-1:0] cur_idx;
  logic [ID_W-1:0] cur_id;
  logic push, pop, full, empty;
  logic unused_low;
  assign unused_low = ^req_addr[2:0];
  assign full = count == (FW+1)'(REQ_FIFO_DEPTH);
  assign empty = count == '0;
  assign req_ready = !reset && !full;
  assign push = req_valid && req_ready;
  // pop from IDLE, or straight out of RESPOND on the handshake for back-to-back service
  assign pop = !empty && (state == S_IDLE || (state == S_RESPOND && resp_ready));
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_index] <= ld_data;
  end
  // entries carry the precomputed out-of-range flag instead of the full address
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= {|req_addr[ADDR_W-1:3+IW], req_addr[3 +: IW], req_id};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cnt <= '0;
      cur_oor <= 1'b0;
      cur_idx <= '0;
      cur_id <= '0;
      resp_valid <= 1'b0;
      resp_type <= 2'd0;
      resp_payload <= '0;
      resp_id <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (FW+1)'(push) - (FW+1)'(pop);
      case (state)
        S_WAIT: begin
          if (cnt == '0) begin
            // nonblocking read of mem gives old data on a same-cycle loader write
            resp_valid <= 1'b1;
            resp_type <= cur_oor ? 2'd2 : 2'd0;
            resp_payload <= cur_oor ? '0 : mem[cur_idx];
            resp_id <= cur_id;
            state <= S_RESPOND;
          end else cnt <= cnt - 1'b1;
        end
        S_RESPOND: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (pop) begin
        {cur_oor, cur_idx, cur_id} <= fifo[rd_ptr];
        cnt <= 4'(READ_LATENCY - 1);
        state <= S_WAIT;
      end
    end
  end
`ifdef FETCH_RESPONDER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_reads <= '0;
      stat_errors <= '0;
      stat_backpressure <= '0;
    end else begin
      if (resp_valid && resp_ready && resp_type == 2'd0 && stat_reads != '1) stat_reads <= stat_reads + 1'b1;
      if (resp_valid && resp_ready && resp_type == 2'd2 && stat_errors != '1) stat_errors <= stat_errors + 1'b1;
      if (resp_valid && !resp_ready && stat_backpressure != '1) stat_backpressure <= stat_backpressure + 1'b1;
    end
  end
`endif
endmodule
